dsa_interp_ctrl: RTL

Sequencing controller for the bilinear interpolation datapath (`dsa_datapath`). It walks every pixel of a destination image and derives the Q8.8 source coordinate for each one. For each pixel it fetches the four neighbouring source pixels from a byte-wide memory, launches the datapath, waits for its `done`, and writes the result back. It sits between the frame memory and one `dsa_datapath` instance in the sequential mode.

---
 rtl/dsa_interp_ctrl.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dsa_interp_ctrl.sv
// Sequencing controller for the bilinear interpolation datapath.
// Walks the destination image in raster order, derives Q8.8 source coordinates,
// fetches the four neighbours, runs the datapath and writes the result back.
// Optional datapath watchdog and sticky error port: define DSA_CTRL_TIMEOUT_EN.
module dsa_interp_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  src_w,
  input  logic [DIM_W-1:0]  src_h,
  input  logic [DIM_W-1:0]  dst_w,
  input  logic [DIM_W-1:0]  dst_h,
  input  logic [15:0]       step_x,
  input  logic [15:0]       step_y,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              dp_start,
  output logic [7:0]        p00,
  output logic [7:0]        p01,
  output logic [7:0]        p10,
  output logic [7:0]        p11,
  output logic [15:0]       a,
  output logic [15:0]       b,
  input  logic [7:0]        dp_pixel,
  input  logic              dp_done,
  output logic              busy,
`ifdef DSA_CTRL_TIMEOUT_EN
  output logic              error,
`endif
  output logic              done
);

  typedef enum logic [2:0] {
    StIdle, StCoord, StFetch, StStartDp, StWaitDp, StWrite, StNext, StFinish
  } state_e;

  state_e              state_q, state_d;
  logic [DIM_W-1:0]    src_w_q, src_w_d, src_h_q, src_h_d;
  logic [DIM_W-1:0]    dst_w_q, dst_w_d, dst_h_q, dst_h_d;
  logic [15:0]         step_x_q, step_x_d, step_y_q, step_y_d;
  logic [ADDR_W-1:0]   src_base_q, src_base_d, dst_base_q, dst_base_d;
  logic [DIM_W-1:0]    dx_q, dx_d, dy_q, dy_d;
  logic [15:0]         x_acc_q, x_acc_d, y_acc_q, y_acc_d;
  logic [DIM_W-1:0]    x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [15:0]         a_q, a_d, b_q, b_d;
  logic [2:0]          k_q, k_d;
  logic [7:0]          p_q [4];
  logic [7:0]          p_d [4];
  logic [7:0]          pix_q, pix_d;
`ifdef DSA_CTRL_TIMEOUT_EN
  logic [7:0]          wd_q, wd_d;
  logic                error_q, error_d;
`endif

  // Clamped neighbour coordinates and memory addresses
  logic [DIM_W-1:0]  sw_m1, sh_m1, dw_m1, dh_m1;
  logic [DIM_W-1:0]  x_int, y_int, x0_n, x1_n, y0_n, y1_n, fx, fy;
  logic [ADDR_W-1:0] rd_addr_calc, wr_addr_calc;
  logic [1:0]        k_idx;

  assign sw_m1  = src_w_q - DIM_W'(1);
  assign sh_m1  = src_h_q - DIM_W'(1);
  assign dw_m1  = dst_w_q - DIM_W'(1);
  assign dh_m1  = dst_h_q - DIM_W'(1);
  assign x_int  = {{(DIM_W-8){1'b0}}, x_acc_q[15:8]};
  assign y_int  = {{(DIM_W-8){1'b0}}, y_acc_q[15:8]};
  assign x0_n   = (x_int > sw_m1) ? sw_m1 : x_int;
  assign x1_n   = (x0_n < sw_m1) ? x0_n + DIM_W'(1) : sw_m1;
  assign y0_n   = (y_int > sh_m1) ? sh_m1 : y_int;
  assign y1_n   = (y0_n < sh_m1) ? y0_n + DIM_W'(1) : sh_m1;
  // k=0..3 walks (x0,y0),(x1,y0),(x0,y1),(x1,y1)
  assign fx     = k_q[0] ? x1_q : x0_q;
  assign fy     = k_q[1] ? y1_q : y0_q;
  assign rd_addr_calc = src_base_q + ADDR_W'(fy) * ADDR_W'(src_w_q) + ADDR_W'(fx);
  assign wr_addr_calc = dst_base_q + ADDR_W'(dy_q) * ADDR_W'(dst_w_q) + ADDR_W'(dx_q);
  // Read data arriving on k=1..4 belongs to the read issued one cycle earlier
  assign k_idx  = k_q[1:0] - 2'd1;

  assign p00  = p_q[0];
  assign p01  = p_q[1];
  assign p10  = p_q[2];
  assign p11  = p_q[3];
  assign a    = a_q;
  assign b    = b_q;
  assign busy = (state_q != StIdle);
`ifdef DSA_CTRL_TIMEOUT_EN
  assign error = error_q;
`endif

  // Next-state, datapath register updates and strobes
  always_comb begin
    state_d    = state_q;
    src_w_d    = src_w_q;
    src_h_d    = src_h_q;
    dst_w_d    = dst_w_q;
    dst_h_d    = dst_h_q;
    step_x_d   = step_x_q;
    step_y_d   = step_y_q;
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    x_acc_d    = x_acc_q;
    y_acc_d    = y_acc_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    a_d        = a_q;
    b_d        = b_q;
    k_d        = k_q;
    p_d        = p_q;
    pix_d      = pix_q;
`ifdef DSA_CTRL_TIMEOUT_EN
    wd_d       = wd_q;
    error_d    = error_q;
`endif
    rd_en      = 1'b0;
    rd_addr    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    dp_start   = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_w_d    = src_w;
          src_h_d    = src_h;
          dst_w_d    = dst_w;
          dst_h_d    = dst_h;
          step_x_d   = step_x;
          step_y_d   = step_y;
          src_base_d = src_base;
          dst_base_d = dst_base;
          dx_d       = '0;
          dy_d       = '0;
          x_acc_d    = '0;
          y_acc_d    = '0;
`ifdef DSA_CTRL_TIMEOUT_EN
          error_d    = 1'b0;
`endif
          state_d = (dst_w == '0 || dst_h == '0) ? StFinish : StCoord;
        end
      end
      StCoord: begin
        x0_d    = x0_n;
        x1_d    = x1_n;
        y0_d    = y0_n;
        y1_d    = y1_n;
        a_d     = {8'h00, x_acc_q[7:0]};
        b_d     = {8'h00, y_acc_q[7:0]};
        k_d     = '0;
        state_d = StFetch;
      end
      StFetch: begin
        if (k_q != 3'd4) begin
          rd_en   = 1'b1;
          rd_addr = rd_addr_calc;
        end
        if (k_q != 3'd0) p_d[k_idx] = rd_data;
        if (k_q == 3'd4) begin
          k_d     = '0;
          state_d = StStartDp;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      StStartDp: begin
        dp_start = 1'b1;
`ifdef DSA_CTRL_TIMEOUT_EN
        wd_d     = '0;
`endif
        state_d  = StWaitDp;
      end
      StWaitDp: begin
        if (dp_done) begin
          pix_d   = dp_pixel;
          state_d = StWrite;
        end
`ifdef DSA_CTRL_TIMEOUT_EN
        // 256th cycle without completion: abandon the frame without writing
        else if (wd_q == 8'hFF) begin
          error_d = 1'b1;
          state_d = StFinish;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      StWrite: begin
        wr_en   = 1'b1;
        wr_addr = wr_addr_calc;
        wr_data = pix_q;
        state_d = StNext;
      end
      StNext: begin
        if (dx_q < dw_m1) begin
          dx_d    = dx_q + DIM_W'(1);
          x_acc_d = x_acc_q + step_x_q;
        end else begin
          dx_d    = '0;
          x_acc_d = '0;
          dy_d    = dy_q + DIM_W'(1);
          y_acc_d = y_acc_q + step_y_q;
        end
        state_d = (dx_q == dw_m1 && dy_q == dh_m1) ? StFinish : StCoord;
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      src_w_q    <= '0;
      src_h_q    <= '0;
      dst_w_q    <= '0;
      dst_h_q    <= '0;
      step_x_q   <= '0;
      step_y_q   <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      x_acc_q    <= '0;
      y_acc_q    <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      p_q        <= '{default: '0};
      pix_q      <= '0;
`ifdef DSA_CTRL_TIMEOUT_EN
      wd_q       <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      src_w_q    <= src_w_d;
      src_h_q    <= src_h_d;
      dst_w_q    <= dst_w_d;
      dst_h_q    <= dst_h_d;
      step_x_q   <= step_x_d;
      step_y_q   <= step_y_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      x_acc_q    <= x_acc_d;
      y_acc_q    <= y_acc_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      a_q        <= a_d;
      b_q        <= b_d;
      k_q        <= k_d;
      p_q        <= p_d;
      pix_q      <= pix_d;
`ifdef DSA_CTRL_TIMEOUT_EN
      wd_q       <= wd_d;
      error_q    <= error_d;
`endif
    end
  end

endmodule
